// File: rtl/cordic_share_arbiter.sv
// Shares one CORDIC between two IQ AXI-Stream channels: packet-level round-robin
// issue, with a tag FIFO steering in-order CORDIC results back to their owner.
module cordic_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,

  input  logic                          s00_axis_tvalid,
  input  logic                          s00_axis_tlast,
  input  logic [DATA_WIDTH-1:0]         s00_axis_tdata,
  output logic                          s00_axis_tready,

  input  logic                          s01_axis_tvalid,
  input  logic                          s01_axis_tlast,
  input  logic [DATA_WIDTH-1:0]         s01_axis_tdata,
  output logic                          s01_axis_tready,

  output logic                          mc_axis_tvalid,
  output logic                          mc_axis_tlast,
  output logic [DATA_WIDTH-1:0]         mc_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       mc_axis_tstrb,
  input  logic                          mc_axis_tready,

  input  logic                          sc_axis_tvalid,
  input  logic                          sc_axis_tlast,
  input  logic [DATA_WIDTH-1:0]         sc_axis_tdata,
  output logic                          sc_axis_tready,

  output logic                          m00_axis_tvalid,
  output logic                          m00_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m00_axis_tstrb,
  input  logic                          m00_axis_tready,

  output logic                          m01_axis_tvalid,
  output logic                          m01_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m01_axis_tstrb,
  input  logic                          m01_axis_tready,

  output logic [1:0]                    grant,
  output logic [$clog2(TAG_DEPTH):0]    tags_inflight,
  output logic                          err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t               state, state_next;
  logic                 rr_pref, rr_pref_next;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, empty, head;
  logic                 push, pop, push_tag;

  assign full  = (count == CNT_W'(TAG_DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // Issue side: the locked channel is wired straight through to the CORDIC,
  // gated only by tag FIFO space (a pop in the same cycle does not free a slot).
  always_comb begin
    state_next      = state;
    rr_pref_next    = rr_pref;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    mc_axis_tvalid  = 1'b0;
    mc_axis_tdata   = s00_axis_tdata;
    mc_axis_tlast   = s00_axis_tlast;
    push            = 1'b0;
    push_tag        = 1'b0;
    grant           = 2'b00;

    case (state)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid)
          state_next = rr_pref ? LOCK1 : LOCK0;
        else if (s00_axis_tvalid)
          state_next = LOCK0;
        else if (s01_axis_tvalid)
          state_next = LOCK1;
      end
      LOCK0: begin
        grant           = 2'b01;
        mc_axis_tvalid  = s00_axis_tvalid & ~full;
        s00_axis_tready = mc_axis_tready & ~full;
        push            = mc_axis_tvalid & mc_axis_tready;
        if (push && s00_axis_tlast) begin
          state_next   = IDLE;
          rr_pref_next = 1'b1;
        end
      end
      LOCK1: begin
        grant           = 2'b10;
        mc_axis_tvalid  = s01_axis_tvalid & ~full;
        s01_axis_tready = mc_axis_tready & ~full;
        mc_axis_tdata   = s01_axis_tdata;
        mc_axis_tlast   = s01_axis_tlast;
        push            = mc_axis_tvalid & mc_axis_tready;
        push_tag        = 1'b1;
        if (push && s01_axis_tlast) begin
          state_next   = IDLE;
          rr_pref_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Return side: the head tag alone decides the destination, so a stalled
  // destination blocks the other channel too.
  assign m00_axis_tvalid = sc_axis_tvalid & ~empty & ~head;
  assign m01_axis_tvalid = sc_axis_tvalid & ~empty & head;
  assign sc_axis_tready  = ~empty & (head ? m01_axis_tready : m00_axis_tready);
  assign pop             = sc_axis_tvalid & sc_axis_tready;

  assign m00_axis_tdata  = sc_axis_tdata;
  assign m00_axis_tlast  = sc_axis_tlast;
  assign m01_axis_tdata  = sc_axis_tdata;
  assign m01_axis_tlast  = sc_axis_tlast;

  assign mc_axis_tstrb   = '1;
  assign m00_axis_tstrb  = '1;
  assign m01_axis_tstrb  = '1;
  assign tags_inflight   = count;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state      <= IDLE;
      rr_pref    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state   <= state_next;
      rr_pref <= rr_pref_next;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (sc_axis_tvalid && empty)
        err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge s00_axis_aclk) begin
    if (push)
      tag_mem[wr_ptr] <= push_tag;
  end

endmodule
